// File: rtl/sample_history_if.sv
// sample_history_if: bundle between the sampler, its buttons, the sensor
// front end and the graph plotter. The slave side is the sampler itself.
interface sample_history_if;
    logic        start_pulse;
    logic        clear_pulse;
    logic        period_up;
    logic        period_down;
    logic        sens_req;
    logic        sens_ack;
    logic [8:0]  sens_data;
    logic [4:0]  rd_col;
    logic [8:0]  rd_height;
    logic        rd_valid;
    logic [39:0] period_ascii;
    logic        running;
    logic [4:0]  count;
    logic        timeout_err;

    modport master (
        output start_pulse, clear_pulse, period_up, period_down,
        output sens_ack, sens_data, rd_col,
        input  sens_req, rd_height, rd_valid, period_ascii,
        input  running, count, timeout_err
    );

    modport slave (
        input  start_pulse, clear_pulse, period_up, period_down,
        input  sens_ack, sens_data, rd_col,
        output sens_req, rd_height, rd_valid, period_ascii,
        output running, count, timeout_err
    );
endinterface

// File: rtl/sample_history.sv
// sample_history: periodic sensor sampler with a DEPTH-entry ring history.
// Optional: define SAMPLE_HISTORY_TIMEOUT_EN for the sensor ack timeout.
module sample_history #(
    parameter int CLK_HZ     = 82_000_000,
    parameter int DEPTH      = 20,
    parameter int YMAX       = 299,
    parameter int TIMEOUT_MS = 100
) (
    input  logic            clk,
    input  logic            rst,
    sample_history_if.slave bus
);
    localparam int DIV = CLK_HZ / 1000;
    localparam int TW  = $clog2(DIV + 1);
    localparam int MSMAX = (60000 > TIMEOUT_MS) ? 60000 : TIMEOUT_MS;
    localparam int EW  = $clog2(MSMAX + 2);

    typedef enum logic [1:0] {IDLE, WAIT, REQ, STORE} state_e;

    state_e       state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic         tick;
    logic [EW-1:0] elapsed_q, elapsed_d;
    logic [EW-1:0] target;
    logic [3:0]   tens_q, tens_d;
    logic [3:0]   units_q, units_d;
    logic [4:0]   wr_ptr_q, wr_ptr_d;
    logic [4:0]   count_q, count_d;
    logic [8:0]   data_q, data_d;
    logic [8:0]   mem_q [DEPTH];
    logic         wr_en;
    logic         enter_wait;
    logic         running_q;
    logic [8:0]   rd_height_q, rd_height_d;
    logic         rd_valid_q, rd_valid_d;
    logic [6:0]   rd_sum;
    logic [4:0]   rd_idx;
`ifdef SAMPLE_HISTORY_TIMEOUT_EN
    logic [EW-1:0] to_q, to_d;
    logic          to_hit;
    logic          timeout_q, timeout_d;
`endif

    assign tick   = (tick_cnt_q == TW'(DIV - 1));
    assign target = EW'(tens_q) * EW'(10000) + EW'(units_q) * EW'(1000);
    assign enter_wait = (state_d == WAIT) && (state_q != WAIT);
    assign wr_en  = (state_q == STORE) && !bus.start_pulse
                    && !bus.clear_pulse;
`ifdef SAMPLE_HISTORY_TIMEOUT_EN
    assign to_hit = (to_q + EW'(1)) >= EW'(TIMEOUT_MS);
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: clear beats start, start toggles run/stop
    always_comb begin
        state_d = state_q;
        if (bus.clear_pulse) begin
            state_d = IDLE;
        end else if (bus.start_pulse) begin
            state_d = (state_q == IDLE) ? REQ : IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                WAIT: begin
                    if (tick && (elapsed_q + EW'(1)) >= target) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (bus.sens_ack) begin
                        state_d = STORE;
                    end
`ifdef SAMPLE_HISTORY_TIMEOUT_EN
                    else if (tick && to_hit) begin
                        state_d = WAIT;
                    end
`endif
                end
                STORE: state_d = WAIT;
            endcase
        end
    end

    // FSM outputs: request follows the registered state
    always_comb begin
        bus.sens_req     = (state_q == REQ);
        bus.running      = running_q;
        bus.count        = count_q;
        bus.rd_height    = rd_height_q;
        bus.rd_valid     = rd_valid_q;
        bus.period_ascii = {4'h3, tens_q, 4'h3, units_q, 24'h303030};
`ifdef SAMPLE_HISTORY_TIMEOUT_EN
        bus.timeout_err  = timeout_q;
`else
        bus.timeout_err  = 1'b0;
`endif
    end

    // Period BCD stepping, ms timing and history pointer next-state
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (bus.period_up && !bus.period_down) begin
            if (!(tens_q == 4'd6 && units_q == 4'd0)) begin
                if (units_q == 4'd9) begin
                    units_d = 4'd0;
                    tens_d  = tens_q + 4'd1;
                end else begin
                    units_d = units_q + 4'd1;
                end
            end
        end else if (bus.period_down && !bus.period_up) begin
            if (!(tens_q == 4'd0 && units_q == 4'd1)) begin
                if (units_q == 4'd0) begin
                    units_d = 4'd9;
                    tens_d  = tens_q - 4'd1;
                end else begin
                    units_d = units_q - 4'd1;
                end
            end
        end

        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        if (enter_wait) begin
            tick_cnt_d = '0;
        end
`ifdef SAMPLE_HISTORY_TIMEOUT_EN
        if (state_d == REQ && state_q != REQ) begin
            tick_cnt_d = '0;
        end
`endif

        elapsed_d = elapsed_q;
        if (state_q == WAIT && tick) begin
            elapsed_d = elapsed_q + EW'(1);
        end
        if (enter_wait || bus.clear_pulse) begin
            elapsed_d = '0;
        end

        data_d = data_q;
        if (state_q == REQ && bus.sens_ack) begin
            data_d = (bus.sens_data > 9'(YMAX)) ? 9'(YMAX) : bus.sens_data;
        end

        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.clear_pulse) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == 5'(DEPTH - 1)) ? '0 : wr_ptr_q + 5'd1;
            if (count_q != 5'(DEPTH)) begin
                count_d = count_q + 5'd1;
            end
        end

`ifdef SAMPLE_HISTORY_TIMEOUT_EN
        to_d = '0;
        if (state_q == REQ) begin
            to_d = tick ? to_q + EW'(1) : to_q;
        end
        timeout_d = timeout_q;
        if (state_q == REQ && state_d == WAIT) begin
            timeout_d = 1'b1;
        end
        if (bus.clear_pulse) begin
            timeout_d = 1'b0;
        end
`endif
    end

    // Control and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            elapsed_q  <= '0;
            tens_q     <= 4'd1;
            units_q    <= 4'd0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            data_q     <= '0;
            running_q  <= 1'b0;
`ifdef SAMPLE_HISTORY_TIMEOUT_EN
            to_q       <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            tick_cnt_q <= tick_cnt_d;
            elapsed_q  <= elapsed_d;
            tens_q     <= tens_d;
            units_q    <= units_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            running_q  <= (state_d != IDLE);
`ifdef SAMPLE_HISTORY_TIMEOUT_EN
            to_q       <= to_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    // History RAM write; contents stay unreset and are masked by count
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_q;
        end
    end

    // Map graph column onto ring slot, oldest sample at column 0
    always_comb begin
        rd_sum = 7'(wr_ptr_q) + 7'(DEPTH) - 7'(count_q) + 7'(bus.rd_col);
        if (rd_sum >= 7'(2 * DEPTH)) begin
            rd_idx = 5'(rd_sum - 7'(2 * DEPTH));
        end else if (rd_sum >= 7'(DEPTH)) begin
            rd_idx = 5'(rd_sum - 7'(DEPTH));
        end else begin
            rd_idx = 5'(rd_sum);
        end
        rd_valid_d  = (bus.rd_col < count_q);
        rd_height_d = rd_valid_d ? mem_q[rd_idx] : 9'd0;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_height_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_height_q <= rd_height_d;
            rd_valid_q  <= rd_valid_d;
        end
    end
endmodule

// File: tb/tb_sample_history.sv
// tb_sample_history: table vectors, hand sequences and a queue model
// of the sample history, period register and read port.
`timescale 1ns/1ps
module tb_sample_history;
    localparam int CLK_HZ = 4000;
    localparam int DIV    = CLK_HZ / 1000;
    localparam int DEPTH  = 20;
    localparam int YMAX   = 299;
    localparam int TMO    = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sample_history_if bus();

    sample_history #(
        .CLK_HZ(CLK_HZ), .DEPTH(DEPTH), .YMAX(YMAX), .TIMEOUT_MS(TMO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int hist[$];
    int p = 10;

    typedef struct {
        bit          up;
        bit          dn;
        int          reps;
        logic [39:0] exp;
    } per_vec_t;

    per_vec_t pv[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] asc(input int v);
        logic [7:0] t;
        logic [7:0] u;
        t = 8'h30 + 8'(v / 10);
        u = 8'h30 + 8'(v % 10);
        return {t, u, 24'h303030};
    endfunction

    function automatic int next_p(input int cur, input bit up, input bit dn);
        if (up && !dn && cur < 60) return cur + 1;
        if (dn && !up && cur > 1) return cur - 1;
        return cur;
    endfunction

    task automatic push(input int d);
        hist.push_back(d > YMAX ? YMAX : d);
        if (hist.size() > DEPTH) void'(hist.pop_front());
    endtask

    task automatic rd_check(input int col);
        int ev;
        int eh;
        bus.rd_col = 5'(col);
        step();
        ev = (col < hist.size()) ? 1 : 0;
        eh = ev ? hist[col] : 0;
        chk($sformatf("rd_valid[%0d]", col), 64'(bus.rd_valid), 64'(ev));
        chk($sformatf("rd_height[%0d]", col), 64'(bus.rd_height), 64'(eh));
    endtask

    task automatic pulse_start();
        bus.start_pulse = 1'b1;
        step();
        bus.start_pulse = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_pulse = 1'b1;
        step();
        bus.clear_pulse = 1'b0;
        hist.delete();
    endtask

    // One quick sample from IDLE: start, ack, then stop again
    task automatic do_sample(input int d);
        pulse_start();
        chk("req_on_start", 64'(bus.sens_req), 64'd1);
        repeat (2) step();
        bus.sens_ack  = 1'b1;
        bus.sens_data = 9'(d);
        step();
        bus.sens_ack = 1'b0;
        push(d);
        repeat (2) step();
        pulse_start();
        chk("sample_count", 64'(bus.count), 64'(hist.size()));
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d;
        bus.start_pulse = 1'b0;
        bus.clear_pulse = 1'b0;
        bus.period_up   = 1'b0;
        bus.period_down = 1'b0;
        bus.sens_ack    = 1'b0;
        bus.sens_data   = '0;
        bus.rd_col      = '0;

        pv[0] = '{1'b1, 1'b0, 60, "60000"};
        pv[1] = '{1'b1, 1'b0, 3,  "60000"};
        pv[2] = '{1'b0, 1'b1, 59, "01000"};
        pv[3] = '{1'b0, 1'b1, 2,  "01000"};
        pv[4] = '{1'b1, 1'b1, 1,  "01000"};
        pv[5] = '{1'b1, 1'b0, 1,  "02000"};
        pv[6] = '{1'b1, 1'b1, 4,  "02000"};
        pv[7] = '{1'b0, 1'b1, 1,  "01000"};

        repeat (3) step();
        rst = 1'b0;
        step();

        chk("rst_ascii", 64'(bus.period_ascii), 64'(asc(10)));
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_req", 64'(bus.sens_req), 64'd0);
        chk("rst_running", 64'(bus.running), 64'd0);
        chk("rst_timeout", 64'(bus.timeout_err), 64'd0);
        for (int c = 0; c < 32; c++) rd_check(c);

        for (int i = 0; i < 8; i++) begin
            repeat (pv[i].reps) begin
                bus.period_up   = pv[i].up;
                bus.period_down = pv[i].dn;
                step();
                p = next_p(p, pv[i].up, pv[i].dn);
            end
            bus.period_up   = 1'b0;
            bus.period_down = 1'b0;
            chk($sformatf("period_vec%0d", i),
                64'(bus.period_ascii), 64'(pv[i].exp));
            chk($sformatf("period_model%0d", i),
                64'(bus.period_ascii), 64'(asc(p)));
        end

        // First sample with P=1 and spacing to the next request
        pulse_start();
        chk("first_req", 64'(bus.sens_req), 64'd1);
        chk("first_running", 64'(bus.running), 64'd1);
        repeat (3) step();
        bus.rd_col    = 5'd0;
        bus.sens_ack  = 1'b1;
        bus.sens_data = 9'd150;
        step();
        bus.sens_ack = 1'b0;
        push(150);
        n = 1;
        chk("req_drop", 64'(bus.sens_req), 64'd0);
        while (n < 6000) begin
            step();
            n++;
            if (n == 2) begin
                chk("rd_not_yet", 64'(bus.rd_valid), 64'd0);
                chk("count_one", 64'(bus.count), 64'd1);
            end
            if (n == 3) begin
                chk("rd_visible", 64'(bus.rd_valid), 64'd1);
                chk("rd_150", 64'(bus.rd_height), 64'd150);
            end
            if (bus.sens_req) break;
        end
        chk("spacing", 64'(n), 64'(2 + p * 1000 * DIV));
        d = $urandom_range(0, 511);
        bus.sens_ack  = 1'b1;
        bus.sens_data = 9'(d);
        step();
        bus.sens_ack = 1'b0;
        push(d);
        repeat (3) step();
        pulse_start();
        chk("stop_running", 64'(bus.running), 64'd0);
        chk("count_two", 64'(bus.count), 64'd2);
        rd_check(1);

        // Wrap and saturation
        pulse_clear();
        chk("clear_count", 64'(bus.count), 64'd0);
        for (int v = 1; v <= 25; v++) do_sample(v);
        do_sample(400);
        chk("sat_count", 64'(bus.count), 64'd20);
        rd_check(0);
        chk("wrap_col0", 64'(bus.rd_height), 64'd7);
        rd_check(19);
        chk("wrap_col19", 64'(bus.rd_height), 64'd299);
        rd_check(20);
        chk("col20_invalid", 64'(bus.rd_valid), 64'd0);

        // Random samples and random column reads against the queue model
        repeat (8) do_sample($urandom_range(0, 511));
        repeat (40) rd_check($urandom_range(0, 31));

        // Random period pulses against the period model
        repeat (150) begin
            bus.period_up   = 1'($urandom_range(0, 1));
            bus.period_down = 1'($urandom_range(0, 1));
            p = next_p(p, bus.period_up, bus.period_down);
            step();
            chk("period_rand", 64'(bus.period_ascii), 64'(asc(p)));
        end
        bus.period_up   = 1'b0;
        bus.period_down = 1'b0;

        // Abort with clear and start together while requesting
        pulse_clear();
        pulse_start();
        chk("abort_req_on", 64'(bus.sens_req), 64'd1);
        bus.clear_pulse = 1'b1;
        bus.start_pulse = 1'b1;
        step();
        bus.clear_pulse = 1'b0;
        bus.start_pulse = 1'b0;
        chk("abort_req_off", 64'(bus.sens_req), 64'd0);
        chk("abort_idle", 64'(bus.running), 64'd0);
        bus.sens_ack  = 1'b1;
        bus.sens_data = 9'd77;
        step();
        bus.sens_ack = 1'b0;
        repeat (3) step();
        chk("late_ack_count", 64'(bus.count), 64'd0);
        rd_check(0);

        // Stop pressed during the store cycle drops the sample
        pulse_start();
        bus.sens_ack  = 1'b1;
        bus.sens_data = 9'd55;
        step();
        bus.sens_ack    = 1'b0;
        bus.start_pulse = 1'b1;
        step();
        bus.start_pulse = 1'b0;
        repeat (3) step();
        chk("store_abort_count", 64'(bus.count), 64'd0);
        chk("store_abort_idle", 64'(bus.running), 64'd0);

        // Request with no acknowledge
        pulse_start();
        n = 0;
`ifdef SAMPLE_HISTORY_TIMEOUT_EN
        while (!bus.timeout_err && n < 1000) begin
            step();
            n++;
        end
        chk("timeout_set", 64'(bus.timeout_err), 64'd1);
        chk("timeout_cycles", 64'(n), 64'(TMO * DIV));
        chk("timeout_req", 64'(bus.sens_req), 64'd0);
        chk("timeout_wait", 64'(bus.running), 64'd1);
        chk("timeout_count", 64'(bus.count), 64'd0);
`else
        repeat (500) step();
        chk("no_timeout_flag", 64'(bus.timeout_err), 64'd0);
        chk("no_timeout_req", 64'(bus.sens_req), 64'd1);
`endif
        pulse_start();
        chk("final_idle", 64'(bus.running), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sample_history.md
# sample_history

Sampling scheduler and 20-entry temperature history buffer for the measurement screen. It turns keyboard button pulses into a periodic request/acknowledge handshake with the temperature sensor front end. It keeps the last 20 readings in a ring buffer and serves them column by column to the 20x300 graph plotter, which runs on the same VGA pixel clock. It also produces the 5-character ASCII sampling-period string shown under "sample tim".

## Interface
Parameters:
- `CLK_HZ`, 82_000_000: `clk` frequency; the ms tick divisor is `CLK_HZ/1000`.
- `DEPTH`, 20: history entries, one per graph column.
- `YMAX`, 299: largest storable height in graph pixels.
- `TIMEOUT_MS`, 100: sensor acknowledge timeout; only used when `SAMPLE_HISTORY_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock, VGA pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `start_pulse` in 1: one-cycle pulse from the "sample" button; toggles between run and stop.
- `clear_pulse` in 1: one-cycle pulse from the "reset" button; empties the history.
- `period_up` in 1: one-cycle pulse; sampling period +1 s.
- `period_down` in 1: one-cycle pulse; sampling period −1 s.
- `sens_req` out 1: sensor conversion request.
- `sens_ack` in 1: sensor data valid, one cycle.
- `sens_data` in 9: reading in graph pixels.
- `rd_col` in 5: graph column index, 0 is the oldest sample.
- `rd_height` out 9: stored height for `rd_col`.
- `rd_valid` out 1: `rd_col` holds a sample.
- `period_ascii` out 40: period in ms as 5 ASCII digits, MSB is the first character.
- `running` out 1: sampler active.
- `count` out 5: number of stored samples, 0..DEPTH.
- `timeout_err` out 1: sticky acknowledge-timeout flag.

## Operation
- **Period register:** two BCD digits P, range 01..60, in seconds. Reset value 10.
  - `period_up` at 60 has no effect; `period_down` at 01 has no effect.
  - Both pulses in the same cycle: ignored.
  - `period_ascii` = {tens, units, "0","0","0"}. Reset value is "10000".
- **ms tick:** a counter runs 0..CLK_HZ/1000−1 and emits a one-cycle tick at wrap. The counter is cleared on entering WAIT.
- **Elapsed counter:** counts ms ticks in WAIT.
- **State machine:**
  - IDLE: `running`=0. `start_pulse` → REQ, so the first sample is taken immediately.
  - WAIT: when the elapsed count is at least P*1000 on a tick → REQ. A period change takes effect on the next comparison; if the elapsed count already exceeds the new period, the sample is taken on the next tick.
  - REQ: `sens_req`=1. `sens_ack` → STORE with `sens_data` captured.
  - STORE: one cycle. Writes min(data, YMAX) at wr_ptr, advances wr_ptr (DEPTH−1 wraps to 0), increments `count` saturating at DEPTH. Then → WAIT with the elapsed count cleared.
  - `start_pulse` in WAIT, REQ or STORE → IDLE. `sens_req` drops next cycle; any in-flight ack is ignored and the current sample is not written.
- **clear_pulse in any state:** wr_ptr=0, `count`=0, `timeout_err`=0, elapsed count cleared. A pending request is aborted. Next state is IDLE.
- **Simultaneous pulses:** clear has priority over start.
- **Read port:** oldest = (wr_ptr − count) mod DEPTH.
  - When `rd_col` < `count`: `rd_height` = mem[(oldest + rd_col) mod DEPTH] and `rd_valid`=1.
  - Otherwise `rd_height`=0 and `rd_valid`=0. This includes every `rd_col` ≥ DEPTH.
- **Handshake:** `sens_req` is held until ack. An ack seen while `sens_req`=0 is ignored.

## Timing
- Reset values: state IDLE, `sens_req`=0, `running`=0, `count`=0, `rd_height`=0, `rd_valid`=0, `timeout_err`=0, wr_ptr=0, P=10.
  - History RAM contents are not reset; they are masked by `count`.
- `sens_req` rises in the cycle after the REQ entry decision, which is registered.
- ack at cycle t → write in cycle t+1. The write is visible on the read port from cycle t+3.
- Read port: registered, 1-cycle latency from `rd_col` to `rd_height`/`rd_valid`.
- Sample spacing in steady state: P*1000 ms ticks plus handshake cycles.
- `count` and `running` are registered outputs of the state and counters.

## Configuration
- `SAMPLE_HISTORY_TIMEOUT_EN` defined:
  - In REQ, a ms counter runs.
  - Reaching TIMEOUT_MS without ack sets `timeout_err`, drops `sens_req` and moves to WAIT with the elapsed count cleared.
  - No sample is stored.
- Not defined:
  - REQ waits indefinitely.
  - `timeout_err` is tied to 0.

## Test plan
Simulate with CLK_HZ=4000, which gives 4 clocks per ms.
- **Reset:** reset, then read all outputs → `period_ascii`="10000", `count`=0, `sens_req`=0, `rd_valid`=0 for `rd_col`=0..31.
- **Period limits:** 60 `period_up` pulses → "60000". Further `period_up` stays "60000". `period_down` ×59 → "01000". Simultaneous up and down → unchanged.
- **First sample and spacing:** P=1, `start_pulse`, ack after 3 cycles with data 150 → `count`=1 and `rd_col`=0 returns 150. The second `sens_req` rises 1000 ms ticks after STORE.
- **Wrap and saturation:** 25 samples with data 1..25, then data 400 → `count`=20; `rd_col`=0 reads 7 and `rd_col`=19 reads 299; `rd_col`=20 gives `rd_valid`=0.
- **Abort:** `clear_pulse` and `start_pulse` in the same cycle while `sens_req`=1 → IDLE, `sens_req`=0 next cycle. A late ack writes nothing and `count` stays 0.
- **Timeout:** with `SAMPLE_HISTORY_TIMEOUT_EN` and no ack → `timeout_err`=1 after 100 ms, `count` unchanged, sampler back in WAIT.
